// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arms, fires and tracks one trigger across NUM_CH channels,
// reporting completion, timeout or BSYNC loss.
module trigger_sequencer #(
  parameter int NUM_CH = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_CH-1:0]     ch_en_mask,
  input  logic [TIMEOUT_W-1:0]  timeout_cycles,
  input  logic                  bsync_ready,
  input  logic                  bsync_event,
  input  logic [3*NUM_CH-1:0]   ch_state,
  output logic [NUM_CH-1:0]     ch_trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [NUM_CH-1:0]     done_mask,
  output logic [2:0]            seq_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, FIRE = 3'd2, WAIT = 3'd3, DONE = 3'd4, ERR = 3'd5} state_t;
  state_t state;
  logic [NUM_CH-1:0] mask_r, seen_adj, is_edge, is_adj, dm_nxt;
  logic [TIMEOUT_W-1:0] timer;
  logic [1:0] fire_cnt;
  logic armed, complete, expire;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign is_edge[i] = ch_state[3*i +: 3] == 3'd1;
    assign is_adj[i]  = ch_state[3*i +: 3] == 3'd3;
  end
  assign armed     = bsync_ready && (mask_r & ~is_edge) == '0;
  assign dm_nxt    = done_mask | (mask_r & seen_adj & is_edge);
  assign complete  = dm_nxt == mask_r;
  assign expire    = timer == TIMEOUT_W'(1);
  assign busy      = state != IDLE;
  assign seq_state = state;
  // A timer of 0 means disabled; an armed timer never reaches 0 because timer==1 forces ERR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      mask_r     <= '0;
      seen_adj   <= '0;
      timer      <= '0;
      fire_cnt   <= '0;
      ch_trigger <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      done_mask  <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      ch_trigger <= '0;
      fire_cnt   <= state != FIRE ? 2'd0 : fire_cnt == 2'd3 ? fire_cnt : fire_cnt + 2'd1;
      if (state inside {ARM, FIRE, WAIT} && timer != '0) timer <= timer - TIMEOUT_W'(1);
      if (abort && state != IDLE) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          if (|ch_en_mask) begin
            mask_r    <= ch_en_mask;
            done_mask <= '0;
            err_code  <= 2'd0;
            seen_adj  <= '0;
            timer     <= timeout_cycles;
            state     <= ARM;
          end else begin
            done_mask <= '0;
            done      <= 1'b1;
          end
        end
        ARM: if (expire) begin
          state    <= ERR;
          err      <= 1'b1;
          err_code <= 2'd1;
        end else if (armed) state <= FIRE;
        FIRE: if (!bsync_ready || expire) begin
          state    <= ERR;
          err      <= 1'b1;
          err_code <= bsync_ready ? 2'd1 : 2'd2;
        end else if (bsync_event && fire_cnt == 2'd3) state <= WAIT;
        else ch_trigger <= mask_r;
        WAIT: begin
          seen_adj  <= seen_adj | (mask_r & is_adj);
          done_mask <= dm_nxt;
          if (complete) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!bsync_ready || expire) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= bsync_ready ? 2'd1 : 2'd2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: scenario timelines derived from the sequencing rules, checked cycle by cycle.
module tb_trigger_sequencer;
  logic clk = 1'b0;
  logic rstn, start, abort, bsync_ready, bsync_event, busy, done, err;
  logic [3:0] ch_en_mask, ch_trigger, done_mask;
  logic [15:0] timeout_cycles;
  logic [11:0] ch_state;
  logic [1:0] err_code;
  logic [2:0] seq_state;
  trigger_sequencer #(.NUM_CH(4), .TIMEOUT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .ch_en_mask(ch_en_mask),
    .timeout_cycles(timeout_cycles), .bsync_ready(bsync_ready), .bsync_event(bsync_event),
    .ch_state(ch_state), .ch_trigger(ch_trigger), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .done_mask(done_mask), .seq_state(seq_state)
  );
  always #5 clk = ~clk;
  localparam int BIG = 1 << 20;
  localparam int K_COMP = 0, K_LOSS = 1, K_TMO = 2, K_ABT = 3;
  int passed = 0, total = 0;
  logic [3:0] mask;
  int r, dly, early, N, L, A, sb;
  bit loss_en, abort_en, sb_en;
  int h[4], s[4], pp[4], len[4], R[4];
  bit stuck[4];
  int F, W, e, maxR, Z, kind;
  task automatic defaults();
    mask = 4'hF; r = 0; dly = 0; early = 0; N = 0; L = 0; A = 0; sb = 0;
    loss_en = 0; abort_en = 0; sb_en = 0;
    for (int i = 0; i < 4; i++) begin
      h[i] = 0; s[i] = 0; pp[i] = 0; len[i] = 1; stuck[i] = 0;
    end
  endtask
  // Timeline relative to the start cycle (cycle 0): ARM from 1, FIRE from F, WAIT from W,
  // channel i back in TRIG_EDGE at R[i], terminal state (DONE/ERR/IDLE on abort) at Z.
  task automatic plan();
    int hm, dmin;
    hm = 0;
    for (int i = 0; i < 4; i++) if (mask[i] && h[i] > hm) hm = h[i];
    F = (r > 1) ? r : 1;
    if (hm > F) F = hm;
    F = F + 1;
    e = F + 3 + dly;
    W = e + 1;
    maxR = 0;
    for (int i = 0; i < 4; i++) begin
      R[i] = stuck[i] ? BIG : W + s[i] + pp[i] + len[i];
      if (mask[i] && R[i] > maxR) maxR = R[i];
    end
    dmin = maxR;
    if (loss_en && L < dmin) dmin = L;
    if (N != 0 && N < dmin) dmin = N;
    if (abort_en && A < dmin) dmin = A;
    kind = (abort_en && A == dmin) ? K_ABT : (maxR == dmin) ? K_COMP : (loss_en && L == dmin) ? K_LOSS : K_TMO;
    Z = dmin + 1;
  endtask
  function automatic logic [2:0] chs(int i, int c);
    int t;
    if (!mask[i]) return 3'($urandom_range(0, 3));
    if (c < h[i]) return 3'd0;
    t = W + s[i];
    if (stuck[i] || c < t) return 3'd1;
    if (c < t + pp[i]) return 3'd2;
    if (c < t + pp[i] + len[i]) return 3'd3;
    return 3'd1;
  endfunction
  task automatic run_seq();
    logic [2:0] es;
    logic [3:0] et, edm;
    logic [1:0] ec;
    logic ed, ee;
    int k;
    if (Z > 2000) begin
      total++;
      $display("FAIL plan_bound: Z=%0d exceeds cycle budget 2000", Z);
      return;
    end
    for (int c = 0; c <= Z + 1; c++) begin
      start = (c == 0) || (sb_en && c == sb);
      ch_en_mask = (c == 0) ? mask : 4'($urandom);
      timeout_cycles = (c == 0) ? 16'(N) : 16'($urandom);
      bsync_ready = c >= r && !(loss_en && c >= L);
      bsync_event = c == e || (early != 0 && c == F + early);
      abort = abort_en && c == A;
      for (int i = 0; i < 4; i++) ch_state[3*i +: 3] = chs(i, c);
      @(posedge clk); #1;
      k = c + 1;
      es = k > Z ? 3'd0 : k == Z ? (kind == K_COMP ? 3'd4 : kind == K_ABT ? 3'd0 : 3'd5) : k < F ? 3'd1 : k < W ? 3'd2 : 3'd3;
      et = (k >= F + 1 && k < W && k < Z) ? mask : 4'd0;
      ec = k < Z ? 2'd0 : kind == K_LOSS ? 2'd2 : kind == K_TMO ? 2'd1 : 2'd0;
      ed = k == Z && kind == K_COMP;
      ee = k == Z && (kind == K_LOSS || kind == K_TMO);
      edm = 4'd0;
      for (int i = 0; i < 4; i++)
        if (mask[i] && !stuck[i] && (R[i] < Z - 1 || (R[i] == Z - 1 && kind != K_ABT)) && k >= R[i] + 1) edm[i] = 1'b1;
      total++; if (seq_state !== es) $display("FAIL seq_state k=%0d got %0d exp %0d", k, seq_state, es); else passed++;
      total++; if (busy !== (es != 3'd0)) $display("FAIL busy k=%0d got %b exp %b", k, busy, es != 3'd0); else passed++;
      total++; if (done !== ed) $display("FAIL done k=%0d got %b exp %b", k, done, ed); else passed++;
      total++; if (err !== ee) $display("FAIL err k=%0d got %b exp %b", k, err, ee); else passed++;
      total++; if (ch_trigger !== et) $display("FAIL ch_trigger k=%0d got %b exp %b", k, ch_trigger, et); else passed++;
      total++; if (done_mask !== edm) $display("FAIL done_mask k=%0d got %b exp %b", k, done_mask, edm); else passed++;
      total++; if (err_code !== ec) $display("FAIL err_code k=%0d got %0d exp %0d", k, err_code, ec); else passed++;
    end
    start = 0; abort = 0; bsync_event = 0;
  endtask
  task automatic test_reset();
    #12;
    total++; if (seq_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", seq_state); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_pulses got done=%b err=%b exp 0", done, err); else passed++;
    total++; if (ch_trigger !== 4'd0) $display("FAIL reset_trigger got %b exp 0000", ch_trigger); else passed++;
    total++; if (done_mask !== 4'd0) $display("FAIL reset_done_mask got %b exp 0000", done_mask); else passed++;
    total++; if (err_code !== 2'd0) $display("FAIL reset_err_code got %0d exp 0", err_code); else passed++;
  endtask
  task automatic test_basic();
    defaults(); mask = 4'b0101; dly = 3; len[0] = 5; len[2] = 5;
    plan(); run_seq();
    total++; if (done_mask !== 4'b0101) $display("FAIL basic_done_mask got %b exp 0101", done_mask); else passed++;
  endtask
  task automatic test_timeout();
    defaults(); mask = 4'b0101; dly = 3; len[0] = 5; len[2] = 5; stuck[2] = 1; N = 20;
    plan(); run_seq();
    total++; if (err_code !== 2'd1) $display("FAIL timeout_code got %0d exp 1", err_code); else passed++;
    total++; if (done_mask !== 4'b0001) $display("FAIL timeout_partial got %b exp 0001", done_mask); else passed++;
  endtask
  task automatic test_bsync_loss();
    defaults(); for (int i = 0; i < 4; i++) len[i] = 6; len[1] = 1;
    plan(); loss_en = 1; L = W + 3; plan(); run_seq();
    total++; if (err_code !== 2'd2) $display("FAIL loss_wait_code got %0d exp 2", err_code); else passed++;
    defaults(); plan(); loss_en = 1; L = F + 1; plan(); run_seq();
  endtask
  task automatic test_abort();
    defaults(); plan(); abort_en = 1; A = F + 1; plan(); run_seq();
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL abort_fire_pulse got done=%b err=%b exp 0", done, err); else passed++;
    defaults(); for (int i = 1; i < 4; i++) len[i] = 6;
    plan(); abort_en = 1; A = W + 3; plan(); run_seq();
    defaults(); r = 3; plan(); abort_en = 1; A = 2; plan(); run_seq();
  endtask
  task automatic test_zero_mask();
    defaults(); mask = 4'b0011; plan(); run_seq();
    start = 1; ch_en_mask = 4'd0;
    @(posedge clk); #1;
    start = 0;
    total++; if (done !== 1'b1) $display("FAIL zero_mask_done got %b exp 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_mask_busy got %b exp 0", busy); else passed++;
    total++; if (done_mask !== 4'd0) $display("FAIL zero_mask_clear got %b exp 0000", done_mask); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_mask_after got done=%b busy=%b exp 0 0", done, busy); else passed++;
  endtask
  task automatic test_busy_start();
    defaults(); mask = 4'b0011; plan(); sb_en = 1; sb = F + 1; run_seq();
    total++; if (done_mask !== 4'b0011) $display("FAIL busy_start_mask got %b exp 0011", done_mask); else passed++;
    defaults(); mask = 4'b1000; len[3] = 3; plan(); sb_en = 1; sb = Z; run_seq();
  endtask
  task automatic test_tie_and_early();
    defaults(); early = 1; dly = 2; len[0] = 2; len[1] = 4; len[2] = 3; len[3] = 1;
    plan(); N = maxR; plan(); run_seq();
    total++; if (err_code !== 2'd0) $display("FAIL tie_err_code got %0d exp 0", err_code); else passed++;
    defaults(); early = 2; plan(); N = maxR - 1; plan(); run_seq();
  endtask
  task automatic test_random();
    bit any_stuck;
    for (int it = 0; it < 30; it++) begin
      defaults();
      mask = 4'($urandom_range(1, 15)); r = int'($urandom_range(0, 3));
      dly = int'($urandom_range(0, 4)); early = int'($urandom_range(0, 2));
      any_stuck = 0;
      for (int i = 0; i < 4; i++) begin
        h[i] = int'($urandom_range(0, 3)); s[i] = int'($urandom_range(0, 3));
        pp[i] = int'($urandom_range(0, 2)); len[i] = int'($urandom_range(1, 6));
        stuck[i] = $urandom_range(0, 7) == 0;
        if (stuck[i] && mask[i]) any_stuck = 1;
      end
      N = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
      if (any_stuck && N == 0) N = int'($urandom_range(1, 40));
      plan();
      if ($urandom_range(0, 3) == 0) begin loss_en = 1; L = F + int'($urandom_range(0, W - F + 8)); plan(); end
      if ($urandom_range(0, 4) == 0) begin abort_en = 1; A = int'($urandom_range(1, Z - 1)); plan(); end
      if ($urandom_range(0, 2) == 0) begin sb_en = 1; sb = int'($urandom_range(1, kind == K_ABT ? Z - 1 : Z)); end
      run_seq();
    end
  endtask
  task automatic test_async_reset();
    start = 1; ch_en_mask = 4'hF; timeout_cycles = 16'd0; bsync_ready = 1; bsync_event = 0; ch_state = 12'h249;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ch_trigger !== 4'hF) $display("FAIL arst_pre_trigger got %b exp 1111", ch_trigger); else passed++;
    #2 rstn = 0;
    #1;
    total++; if (ch_trigger !== 4'd0) $display("FAIL arst_trigger got %b exp 0000", ch_trigger); else passed++;
    total++; if (seq_state !== 3'd0 || busy !== 1'b0) $display("FAIL arst_state got %0d busy=%b exp 0 0", seq_state, busy); else passed++;
    #1 rstn = 1;
    @(posedge clk); #1;
    total++; if (seq_state !== 3'd0) $display("FAIL arst_after got %0d exp 0", seq_state); else passed++;
  endtask
  initial begin
    rstn = 0; start = 0; abort = 0; ch_en_mask = 0; timeout_cycles = 0;
    bsync_ready = 0; bsync_event = 0; ch_state = 0;
    test_reset();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    test_basic();
    test_timeout();
    test_bsync_loss();
    test_abort();
    test_zero_mask();
    test_busy_start();
    test_tie_and_early();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
